// File: rtl/time_set_ctrl_if.sv
// Key/timebase inputs and field-select/strobe outputs of the time-setting controller.
interface time_set_ctrl_if;
  logic tick;
  logic key_next;
  logic key_up;
  logic set_day;
  logic set_hour;
  logic set_min;
  logic set_sec;
  logic up_pulse;
  logic blink;
  logic setting;

  modport master (
    output tick, key_next, key_up,
    input  set_day, set_hour, set_min, set_sec, up_pulse, blink, setting
  );

  modport slave (
    input  tick, key_next, key_up,
    output set_day, set_hour, set_min, set_sec, up_pulse, blink, setting
  );
endinterface

// File: rtl/time_set_ctrl.sv
// Manual time/date setting sequencer: field walk, up-key pulses with auto-repeat,
// blink strobe for the selected digits and idle timeout back to RUN.
module time_set_ctrl #(
  parameter int HOLD_TICKS    = 500,
  parameter int REPEAT_TICKS  = 100,  // must not exceed HOLD_TICKS
  parameter int TIMEOUT_TICKS = 10000,
  parameter int BLINK_TICKS   = 250
) (
  input  logic           clock,
  input  logic           reset,
  time_set_ctrl_if.slave ctrl
);

  localparam logic [2:0] RUN      = 3'd0;
  localparam logic [2:0] SET_DAY  = 3'd1;
  localparam logic [2:0] SET_HOUR = 3'd2;
  localparam logic [2:0] SET_MIN  = 3'd3;
  localparam logic [2:0] SET_SEC  = 3'd4;

  localparam int IDLE_W  = $clog2(TIMEOUT_TICKS + 1);
  localparam int REP_W   = $clog2(HOLD_TICKS + 1);
  localparam int BLINK_W = $clog2(BLINK_TICKS + 1);

  localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(TIMEOUT_TICKS - 1);
  localparam logic [IDLE_W-1:0]  IDLE_MAX   = IDLE_W'(TIMEOUT_TICKS);
  localparam logic [REP_W-1:0]   REP_LAST   = REP_W'(HOLD_TICKS - 1);
  localparam logic [REP_W-1:0]   REP_RELOAD = REP_W'(HOLD_TICKS - REPEAT_TICKS);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

  logic [2:0]         state_q, state_d;
  logic               next_q, up_q;
  logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic [REP_W-1:0]   rep_cnt_q, rep_cnt_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_q, blink_d;
  logic               up_pulse_q, up_pulse_d;
  logic               up_armed_q, up_armed_d;

  logic in_set, next_rise, up_rise, timeout, state_change, rep_hit;

  assign in_set       = (state_q != RUN);
  assign next_rise    = ctrl.key_next & ~next_q;
  assign up_rise      = ctrl.key_up & ~up_q;
  assign timeout      = in_set & ctrl.tick & ~ctrl.key_up & (idle_cnt_q == IDLE_LAST);
  assign state_change = (state_d != state_q);
  // After the first repeat the counter reloads so the next hit is REPEAT_TICKS away.
  assign rep_hit      = ctrl.key_up & ~up_rise & ctrl.tick & (rep_cnt_q == REP_LAST);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path infers a latch.
    state_d = state_q;
    if (next_rise) begin
      case (state_q)
        RUN:      state_d = SET_DAY;
        SET_DAY:  state_d = SET_HOUR;
        SET_HOUR: state_d = SET_MIN;
        SET_MIN:  state_d = SET_SEC;
        default:  state_d = RUN;
      endcase
    end else if (timeout) begin
      state_d = RUN;
    end
  end

  always_comb begin
    idle_cnt_d  = idle_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;

    if (!in_set || state_change || next_rise || ctrl.key_up) begin
      idle_cnt_d = '0;
    end else if (ctrl.tick && idle_cnt_q != IDLE_MAX) begin
      idle_cnt_d = idle_cnt_q + IDLE_W'(1);
    end

    if (!ctrl.key_up || up_rise) begin
      rep_cnt_d = '0;
    end else if (ctrl.tick) begin
      rep_cnt_d = rep_hit ? REP_RELOAD : rep_cnt_q + REP_W'(1);
    end

    // Digit stays lit while adjusting; a fresh field starts a fresh blink phase.
    if (state_d == RUN || state_change || ctrl.key_up) begin
      blink_d     = 1'b0;
      blink_cnt_d = '0;
    end else if (ctrl.tick) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_d     = ~blink_q;
        blink_cnt_d = '0;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end
  end

  assign up_pulse_d = in_set & ~state_change & up_armed_q & (up_rise | rep_hit);
  assign up_armed_d = !ctrl.key_up ? 1'b1 : (state_change ? 1'b0 : up_armed_q);

  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q     <= RUN;
      next_q      <= 1'b0;
      up_q        <= 1'b0;
      idle_cnt_q  <= '0;
      rep_cnt_q   <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      up_pulse_q  <= 1'b0;
      up_armed_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      next_q      <= ctrl.key_next;
      up_q        <= ctrl.key_up;
      idle_cnt_q  <= idle_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      up_pulse_q  <= up_pulse_d;
      up_armed_q  <= up_armed_d;
    end
  end

  assign ctrl.set_day  = (state_q == SET_DAY);
  assign ctrl.set_hour = (state_q == SET_HOUR);
  assign ctrl.set_min  = (state_q == SET_MIN);
  assign ctrl.set_sec  = (state_q == SET_SEC);
  assign ctrl.setting  = in_set;
  assign ctrl.up_pulse = up_pulse_q;
  assign ctrl.blink    = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with short timer parameters; tick every 4 clocks.
module tb_time_set_ctrl;
  localparam int HOLD = 4, REP = 2, TMO = 20, BLK = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  time_set_ctrl_if tsi ();

  time_set_ctrl #(
    .HOLD_TICKS(HOLD), .REPEAT_TICKS(REP), .TIMEOUT_TICKS(TMO), .BLINK_TICKS(BLK)
  ) dut (
    .clock(clock),
    .reset(reset),
    .ctrl (tsi.slave)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int tphase   = 0;
  int pulses   = 0;
  int held, mask, guard, n, exp_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge; return 1 ns after the next rising edge.
  task automatic step(input logic k_next, input logic k_up);
    @(negedge clock);
    tsi.key_next = k_next;
    tsi.key_up   = k_up;
    tsi.tick     = (tphase == 3);
    tphase       = (tphase + 1) % 4;
    @(posedge clock);
    #1;
    if (tsi.up_pulse) pulses++;
  endtask

  task automatic press_next();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) step(1'b0, 1'b0);
    reset = 1'b0;
  endtask

  function automatic logic [3:0] sel();
    return {tsi.set_day, tsi.set_hour, tsi.set_min, tsi.set_sec};
  endfunction

  function automatic logic [6:0] outs();
    return {tsi.setting, tsi.blink, tsi.up_pulse, sel()};
  endfunction

  initial begin
    tsi.tick = 1'b0; tsi.key_next = 1'b0; tsi.key_up = 1'b0;

    // Reset state, then async reset mid-SET_MIN with key_up held.
    repeat (3) step(1'b0, 1'b0);
    reset = 1'b0;
    check("reset_outs", outs(), 7'b0);
    repeat (3) press_next();
    check("min_sel", sel(), 4'b0010);
    repeat (3) step(1'b0, 1'b1);
    #2 reset = 1'b1;
    #1 check("async_rst_outs", outs(), 7'b0);
    repeat (3) step(1'b0, 1'b1);
    reset = 1'b0;
    pulses = 0;
    repeat (5) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    check("rst_held_day", sel(), 4'b1000);
    repeat (30) step(1'b0, 1'b1);
    repeat (14) step(1'b0, 1'b0);
    check("rst_no_pulse", pulses, 0);

    // Field walk with next held two cycles per press.
    do_reset();
    press_next(); check("walk_day",  {tsi.setting, sel()}, 5'b1_1000);
    press_next(); check("walk_hour", {tsi.setting, sel()}, 5'b1_0100);
    press_next(); check("walk_min",  {tsi.setting, sel()}, 5'b1_0010);
    press_next(); check("walk_sec",  {tsi.setting, sel()}, 5'b1_0001);
    press_next(); check("walk_run",  {tsi.setting, sel()}, 5'b0_0000);

    // Single up press: none in RUN, one 1-cycle pulse in SET_HOUR.
    pulses = 0;
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check("run_no_pulse", pulses, 0);
    press_next(); press_next();
    pulses = 0;
    check("hour_pre", tsi.up_pulse, 1'b0);
    step(1'b0, 1'b1);
    check("hour_pulse_on", tsi.up_pulse, 1'b1);
    step(1'b0, 1'b0);
    check("hour_pulse_off", tsi.up_pulse, 1'b0);
    repeat (6) step(1'b0, 1'b0);
    check("hour_pulse_cnt", pulses, 1);

    // Hold-to-repeat in SET_MIN for 12 ticks.
    do_reset();
    repeat (3) press_next();
    pulses = 0; held = 0; mask = 0; guard = 0;
    step(1'b0, 1'b1);
    if (tsi.up_pulse) mask |= 1;
    while (held < 12 && guard < 200) begin
      step(1'b0, 1'b1);
      guard++;
      if (tsi.tick) held++;
      if (tsi.up_pulse) mask |= (1 << held);
    end
    check("rep_bound", guard < 200, 1'b1);
    check("rep_blink_held", tsi.blink, 1'b0);
    repeat (4) step(1'b0, 1'b0);
    check("rep_count", pulses, 6);
    check("rep_ticks", mask, 32'h1551);
    check("rep_still_min", sel(), 4'b0010);

    // Simultaneous next/up rise in SET_DAY; held up stays silent until re-pressed.
    do_reset();
    press_next();
    pulses = 0;
    step(1'b1, 1'b1);
    check("both_hour", {tsi.up_pulse, sel()}, 5'b0_0100);
    repeat (40) step(1'b0, 1'b1);
    check("both_no_pulse", pulses, 0);
    repeat (2) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("repress_pulse", tsi.up_pulse, 1'b1);
    step(1'b0, 1'b0);

    // Blink and idle timeout in SET_SEC, with the idle timer restarted by an up press.
    do_reset();
    repeat (3) press_next();
    step(1'b1, 1'b0);
    check("sec_entry", {tsi.blink, sel()}, 5'b0_0001);
    n = 0; guard = 0;
    while (n < 12 && guard < 200) begin
      step(1'b0, 1'b0);
      guard++;
      if (tsi.tick) begin
        n++;
        exp_b = (n / BLK) % 2;
        check("blink_a", {tsi.setting, tsi.blink}, {1'b1, exp_b[0]});
      end
    end
    step(1'b0, 1'b1);
    check("up_press_sec", {tsi.up_pulse, tsi.blink, sel()}, 6'b10_0001);
    n = 0; guard = 0;
    while (n < TMO && guard < 300) begin
      step(1'b0, 1'b0);
      guard++;
      if (tsi.tick) begin
        n++;
        exp_b = (n / BLK) % 2;
        if (n < TMO) check("blink_b", {tsi.setting, tsi.blink}, {1'b1, exp_b[0]});
      end
    end
    check("tmo_bound", guard < 300, 1'b1);
    check("tmo_run", outs(), 7'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end
endmodule
